// File: rtl/counter_cmd_seq.sv
// Command sequencer for the 8-bit up/down counter: queues LOAD/UP/DOWN/HOLD commands
// and expands them into registered counter controls. Optional abort input: CMD_SEQ_ABORT_EN.
module counter_cmd_seq #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
`ifdef CMD_SEQ_ABORT_EN
  input  logic       abort,
`endif
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_arg,
  output logic       ld_cnt_,
  output logic       count_enb,
  output logic       updn_cnt,
  output logic [7:0] data_in,
  output logic       busy,
  output logic       done
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_UP   = 2'b10;
  localparam logic [1:0] OP_DOWN = 2'b11;

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

  state_t      state_r, state_s;
  logic [9:0]  fifo_mem_r [DEPTH];
  logic [PW:0] wr_ptr_r, rd_ptr_r;
  logic [8:0]  rem_r, rem_s;
  logic [9:0]  head_s;
  logic        empty_s, full_s, push_s, pop_s, flush_s;
  logic        ld_s, enb_s, updn_s, done_s;
  logic [7:0]  data_s;
  logic        dec_ld_s, dec_enb_s, dec_updn_s;
  logic [7:0]  dec_data_s;
  logic [8:0]  dec_rem_s;

`ifdef CMD_SEQ_ABORT_EN
  assign flush_s = abort;
`else
  assign flush_s = 1'b0;
`endif

  // Extra pointer bit distinguishes full from empty when the indices match
  assign empty_s   = (wr_ptr_r == rd_ptr_r);
  assign full_s    = (wr_ptr_r[PW] != rd_ptr_r[PW]) && (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
  assign push_s    = cmd_valid && !full_s && !flush_s;
  assign head_s    = fifo_mem_r[rd_ptr_r[PW-1:0]];
  assign cmd_ready = !full_s;
  assign busy      = (state_r == EXEC) || !empty_s;

  // Decode the FIFO head into the control values of its first cycle
  always_comb begin
    dec_ld_s   = 1'b1;
    dec_enb_s  = 1'b0;
    dec_updn_s = 1'b0;
    dec_data_s = 8'd0;
    dec_rem_s  = {(head_s[7:0] == 8'd0), head_s[7:0]};
    case (head_s[9:8])
      OP_LOAD: begin
        dec_ld_s   = 1'b0;
        dec_data_s = head_s[7:0];
        dec_rem_s  = 9'd1;
      end
      OP_UP: begin
        dec_enb_s  = 1'b1;
        dec_updn_s = 1'b1;
      end
      OP_DOWN: dec_enb_s = 1'b1;
      OP_HOLD: dec_enb_s = 1'b0;
      default: dec_enb_s = 1'b0;
    endcase
  end

  // Next-state, pop decision and next registered control values
  always_comb begin
    state_s = state_r;
    rem_s   = rem_r;
    pop_s   = 1'b0;
    ld_s    = ld_cnt_;
    enb_s   = count_enb;
    updn_s  = updn_cnt;
    data_s  = data_in;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          state_s = EXEC;
          ld_s    = dec_ld_s;
          enb_s   = dec_enb_s;
          updn_s  = dec_updn_s;
          data_s  = dec_data_s;
          rem_s   = dec_rem_s;
          done_s  = (dec_rem_s == 9'd1);
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: begin
        if (rem_r > 9'd1) begin
          rem_s  = rem_r - 9'd1;
          done_s = (rem_r == 9'd2);
        end else if (!empty_s) begin
          // Chain straight into the next command: no idle bubble
          pop_s  = 1'b1;
          ld_s   = dec_ld_s;
          enb_s  = dec_enb_s;
          updn_s = dec_updn_s;
          data_s = dec_data_s;
          rem_s  = dec_rem_s;
          done_s = (dec_rem_s == 9'd1);
        end else begin
          state_s = IDLE;
          ld_s    = 1'b1;
          enb_s   = 1'b0;
          updn_s  = 1'b0;
          data_s  = 8'd0;
          rem_s   = 9'd0;
        end
      end
      default: begin
        state_s = IDLE;
        ld_s    = 1'b1;
        enb_s   = 1'b0;
        updn_s  = 1'b0;
        data_s  = 8'd0;
        rem_s   = 9'd0;
      end
    endcase
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r[PW-1:0]] <= {cmd_op, cmd_arg};
    end
  end

  // State, pointers and registered outputs; reset and abort both return to idle
  always_ff @(posedge clk) begin
    if (rst || flush_s) begin
      state_r   <= IDLE;
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      rem_r     <= 9'd0;
      ld_cnt_   <= 1'b1;
      count_enb <= 1'b0;
      updn_cnt  <= 1'b0;
      data_in   <= 8'd0;
      done      <= 1'b0;
    end else begin
      state_r   <= state_s;
      rem_r     <= rem_s;
      ld_cnt_   <= ld_s;
      count_enb <= enb_s;
      updn_cnt  <= updn_s;
      data_in   <= data_s;
      done      <= done_s;
      if (push_s) wr_ptr_r <= wr_ptr_r + {{PW{1'b0}}, 1'b1};
      if (pop_s)  rd_ptr_r <= rd_ptr_r + {{PW{1'b0}}, 1'b1};
    end
  end
endmodule

// File: tb/tb_counter_cmd_seq.sv
// Self-checking bench for counter_cmd_seq: table-driven vectors plus hand sequences,
// with a behavioural model of the downstream 8-bit counter. Abort test needs CMD_SEQ_ABORT_EN.
module tb_counter_cmd_seq;
  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_UP   = 2'b10;
  localparam logic [1:0] OP_DOWN = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_arg;
  logic       ld_cnt_;
  logic       count_enb;
  logic       updn_cnt;
  logic [7:0] data_in;
  logic       busy;
  logic       done;
`ifdef CMD_SEQ_ABORT_EN
  logic       abort;
`endif

  always #5 clk = ~clk;

  counter_cmd_seq #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef CMD_SEQ_ABORT_EN
    .abort     (abort),
`endif
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .ld_cnt_   (ld_cnt_),
    .count_enb (count_enb),
    .updn_cnt  (updn_cnt),
    .data_in   (data_in),
    .busy      (busy),
    .done      (done)
  );

  // Downstream counter driven by the sequencer outputs
  logic [7:0] cnt_m;
  always @(posedge clk) begin
    if (rst) cnt_m <= 8'h00;
    else if (!ld_cnt_) cnt_m <= data_in;
    else if (count_enb) cnt_m <= updn_cnt ? cnt_m + 8'd1 : cnt_m - 8'd1;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_done, n_dn, first_dn, last_dn, n_hold, first_hold, last_hold, last_up;

  typedef struct packed {
    logic       valid;
    logic [1:0] op;
    logic [7:0] arg;
    logic       ign_updn;
    logic       ld;
    logic       enb;
    logic       updn;
    logic [7:0] data;
    logic       done;
    logic       busy;
    logic       ready;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic reset_stats();
    n_done = 0; n_dn = 0; first_dn = -1; last_dn = -1;
    n_hold = 0; first_hold = -1; last_hold = -1; last_up = -1;
  endtask

  // Advance one clock and sample just after the edge, accumulating run statistics
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (done) n_done++;
    if (count_enb && updn_cnt) last_up = cyc;
    if (ld_cnt_ && count_enb && !updn_cnt) begin
      n_dn++;
      if (first_dn < 0) first_dn = cyc;
      last_dn = cyc;
    end
    if (busy && ld_cnt_ && !count_enb) begin
      n_hold++;
      if (first_hold < 0) first_hold = cyc;
      last_hold = cyc;
    end
  endtask

  task automatic push(input logic [1:0] op, input logic [7:0] arg);
    int w;
    w = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    while (!cmd_ready && w < 200) begin
      tick();
      w++;
    end
    if (!cmd_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL push_wait: cmd_ready stuck at 0, want 1");
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [21:0] act_v, exp_v;
    // {valid, op, arg, ign_updn | ld, enb, updn, data, done, busy, ready, cnt}
    vecs[0]  = '{1'b1, OP_LOAD, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00};
    vecs[1]  = '{1'b1, OP_UP,   8'd3,  1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b1, 8'h00};
    vecs[2]  = '{1'b0, OP_HOLD, 8'd0,  1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 8'h3C};
    vecs[3]  = '{1'b0, OP_HOLD, 8'd0,  1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 8'h3D};
    vecs[4]  = '{1'b0, OP_HOLD, 8'd0,  1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 8'h3E};
    vecs[5]  = '{1'b0, OP_HOLD, 8'd0,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h3F};
    vecs[6]  = '{1'b1, OP_UP,   8'd2,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h3F};
    vecs[7]  = '{1'b1, OP_DOWN, 8'd2,  1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 8'h3F};
    vecs[8]  = '{1'b1, OP_HOLD, 8'd1,  1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 8'h40};
    vecs[9]  = '{1'b1, OP_LOAD, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h41};
    vecs[10] = '{1'b0, OP_HOLD, 8'd0,  1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h40};
    vecs[11] = '{1'b0, OP_HOLD, 8'd0,  1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h3F};
    vecs[12] = '{1'b0, OP_HOLD, 8'd0,  1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 8'h3F};
    vecs[13] = '{1'b0, OP_HOLD, 8'd0,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hFF};

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = OP_HOLD; cmd_arg = 8'd0;
`ifdef CMD_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    reset_stats();
    tick();
    tick();
    check("reset_state", {ld_cnt_, count_enb, updn_cnt, data_in, done, busy, cmd_ready},
          {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
    rst = 1'b0;

    // LOAD 3C + UP 3, then mixed back-to-back UP 2 / DOWN 2 / HOLD 1 / LOAD FF
    for (int i = 0; i < 14; i++) begin
      cmd_valid = vecs[i].valid;
      cmd_op    = vecs[i].op;
      cmd_arg   = vecs[i].arg;
      tick();
      act_v = {ld_cnt_, count_enb, updn_cnt, data_in, done, busy, cmd_ready, cnt_m};
      exp_v = {vecs[i].ld, vecs[i].enb, vecs[i].updn, vecs[i].data, vecs[i].done,
               vecs[i].busy, vecs[i].ready, vecs[i].cnt};
      if (vecs[i].ign_updn) begin
        act_v[19] = 1'b0;
        exp_v[19] = 1'b0;
      end
      check($sformatf("vec%0d", i), {10'd0, act_v}, {10'd0, exp_v});
    end
    cmd_valid = 1'b0;

    // LOAD 00 then DOWN 0 (256 cycles): counter wraps back to 00
    reset_stats();
    push(OP_LOAD, 8'h00);
    push(OP_DOWN, 8'd0);
    for (int i = 0; i < 400 && busy; i++) tick();
    check("down256_count", n_dn, 256);
    check("down256_span", last_dn - first_dn + 1, 256);
    check("down256_done", n_done, 2);
    check("down256_cnt", {24'd0, cnt_m}, 32'h00);

    // Fill the FIFO behind a running UP 10, fifth HOLD 10 must stall
    push(OP_UP, 8'd10);
    reset_stats();
    for (int i = 0; i < 4; i++) push(OP_HOLD, 8'd10);
    cmd_valid = 1'b1; cmd_op = OP_HOLD; cmd_arg = 8'd10;
    check("fill_ready_low", {31'd0, cmd_ready}, 32'd0);
    tick();
    tick();
    check("fill_still_full", {31'd0, cmd_ready}, 32'd0);
    push(OP_HOLD, 8'd10);
    for (int i = 0; i < 200 && busy; i++) tick();
    check("fill_hold_cycles", n_hold, 50);
    check("fill_hold_span", last_hold - first_hold + 1, 50);
    check("fill_no_bubble", first_hold, last_up + 1);
    check("fill_done", n_done, 6);

    // Reset for 2 cycles in the middle of UP 5 with another command queued
    push(OP_UP, 8'd5);
    push(OP_HOLD, 8'd3);
    tick();
    rst = 1'b1;
    tick();
    check("midrst_idle", {ld_cnt_, count_enb, done, busy, cmd_ready},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("midrst_flushed", {ld_cnt_, count_enb, busy}, {1'b1, 1'b0, 1'b0});

`ifdef CMD_SEQ_ABORT_EN
    // Abort in cycle 3 of UP 10 with two commands queued; a same-cycle push is dropped
    reset_stats();
    push(OP_UP, 8'd10);
    push(OP_UP, 8'd1);
    push(OP_HOLD, 8'd1);
    tick();
    abort = 1'b1;
    cmd_valid = 1'b1; cmd_op = OP_HOLD; cmd_arg = 8'd1;
    tick();
    abort = 1'b0;
    cmd_valid = 1'b0;
    check("abort_idle", {ld_cnt_, count_enb, updn_cnt, data_in, done, busy, cmd_ready},
          {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
    repeat (4) tick();
    check("abort_flushed", {busy, count_enb}, 32'd0);
    check("abort_no_done", n_done, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
